// File: rtl/spi_flash_reader.sv
// SPI flash read engine: sends READ_CMD plus a 24-bit address on a mode-0 SPI bus,
// then writes each returned byte to consecutive BRAM addresses.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [10:0] byte_count,
    input  logic [9:0]  bram_base,
    output logic        busy,
    output logic        done,
    output logic        flash_cs,
    output logic        flash_sclk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        bram_ena,
    output logic        bram_wea,
    output logic [9:0]  bram_addra,
    output logic [7:0]  bram_dina
);

    localparam int unsigned MAX_BYTES = 1024;
    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [8:0]  DSEL_MIN  = 9'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        DATA,
        CS_HOLD,
        FINISH
    } state_t;

    function automatic logic [10:0] sat_byte_count(input logic [10:0] n);
        return (n > 11'(MAX_BYTES)) ? 11'(MAX_BYTES) : n;
    endfunction

    state_t      state;
    logic [7:0]  div_cnt;
    logic [8:0]  dsel_cnt;
    logic [4:0]  cmd_bit;
    logic [2:0]  data_bit;
    logic [10:0] bytes_left;
    logic [30:0] cmd_rest;
    logic [6:0]  rx_shift;
    logic [9:0]  wr_addr;

    logic        half_done;
    logic [10:0] req_count;
    logic [7:0]  rx_byte;

    assign half_done = (div_cnt == DIV_LAST);
    assign req_count = sat_byte_count(byte_count);
    assign rx_byte   = {rx_shift, flash_miso};

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            dsel_cnt   <= '0;
            cmd_bit    <= '0;
            data_bit   <= '0;
            bytes_left <= '0;
            cmd_rest   <= '0;
            rx_shift   <= '0;
            wr_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_cs   <= 1'b1;
            flash_sclk <= 1'b0;
            flash_mosi <= 1'b0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else begin
            done     <= 1'b0;
            bram_ena <= 1'b0;
            bram_wea <= 1'b0;

            // Deselect timer: counts cycles with CS high, saturating once the gap is long enough.
            if (flash_cs && (dsel_cnt != DSEL_MIN))
                dsel_cnt <= dsel_cnt + 9'd1;

            case (state)
                IDLE: begin
                    if (start && !done && (dsel_cnt == DSEL_MIN)) begin
                        cmd_rest   <= {READ_CMD[6:0], flash_addr};
                        bytes_left <= req_count;
                        wr_addr    <= bram_base;
                        div_cnt    <= '0;
                        busy       <= 1'b1;
                        if (req_count == 11'd0) begin
                            state <= FINISH;
                        end else begin
                            state      <= CS_SETUP;
                            flash_cs   <= 1'b0;
                            flash_mosi <= READ_CMD[7];
                        end
                    end
                end

                CS_SETUP: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        cmd_bit <= '0;
                        state   <= CMD;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                // MOSI only moves on the falling edge, so it is stable for the whole low half.
                CMD: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!flash_sclk) begin
                            flash_sclk <= 1'b1;
                        end else begin
                            flash_sclk <= 1'b0;
                            if (cmd_bit == 5'd31) begin
                                flash_mosi <= 1'b0;
                                data_bit   <= '0;
                                state      <= DATA;
                            end else begin
                                cmd_bit    <= cmd_bit + 5'd1;
                                flash_mosi <= cmd_rest[30];
                                cmd_rest   <= {cmd_rest[29:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                // MISO is captured on the edge that raises SCLK; the flash launched it on the prior fall.
                DATA: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!flash_sclk) begin
                            flash_sclk <= 1'b1;
                            rx_shift   <= rx_byte[6:0];
                            data_bit   <= data_bit + 3'd1;
                            if (data_bit == 3'd7) begin
                                bram_ena   <= 1'b1;
                                bram_wea   <= 1'b1;
                                bram_addra <= wr_addr;
                                bram_dina  <= rx_byte;
                                wr_addr    <= wr_addr + 10'd1;
                                bytes_left <= bytes_left - 11'd1;
                            end
                        end else begin
                            flash_sclk <= 1'b0;
                            if (bytes_left == 11'd0)
                                state <= CS_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                CS_HOLD: begin
                    if (half_done) begin
                        div_cnt  <= '0;
                        flash_cs <= 1'b1;
                        dsel_cnt <= '0;
                        state    <= FINISH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: a mode-0 flash model per instance returns known
// bytes, monitors log SPI edges and BRAM writes, and one check task scores every result.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: CLK_DIV = 2
    logic        start0 = 1'b0;
    logic [23:0] addr0  = '0;
    logic [10:0] cnt0   = '0;
    logic [9:0]  base0  = '0;
    logic        busy0, done0, cs0, sclk0, mosi0, ena0, wea0;
    logic        miso0  = 1'b0;
    logic [9:0]  addra0;
    logic [7:0]  dina0;

    // Instance 1: CLK_DIV = 1
    logic        start1 = 1'b0;
    logic [23:0] addr1  = '0;
    logic [10:0] cnt1   = '0;
    logic [9:0]  base1  = '0;
    logic        busy1, done1, cs1, sclk1, mosi1, ena1, wea1;
    logic        miso1  = 1'b0;
    logic [9:0]  addra1;
    logic [7:0]  dina1;

    spi_flash_reader #(.CLK_DIV(2), .READ_CMD(8'h03)) u_dut0 (
        .clock_12mhz(clk), .reset(reset), .start(start0), .flash_addr(addr0),
        .byte_count(cnt0), .bram_base(base0), .busy(busy0), .done(done0),
        .flash_cs(cs0), .flash_sclk(sclk0), .flash_mosi(mosi0), .flash_miso(miso0),
        .bram_ena(ena0), .bram_wea(wea0), .bram_addra(addra0), .bram_dina(dina0)
    );

    spi_flash_reader #(.CLK_DIV(1), .READ_CMD(8'h03)) u_dut1 (
        .clock_12mhz(clk), .reset(reset), .start(start1), .flash_addr(addr1),
        .byte_count(cnt1), .bram_base(base1), .busy(busy1), .done(done1),
        .flash_cs(cs1), .flash_sclk(sclk1), .flash_mosi(mosi1), .flash_miso(miso1),
        .bram_ena(ena1), .bram_wea(wea1), .bram_addra(addra1), .bram_dina(dina1)
    );

    logic [7:0]  rom0 [0:1024];
    logic [7:0]  rom1 [0:1024];

    // Monitor and flash model, instance 0
    logic        sclk_q0 = 1'b0;
    logic [31:0] cmd_cap0 = '0;
    logic [17:0] wq0 [$];
    int rise0 = 0, frise0 = 0, wr0 = 0, done_n0 = 0, busy_n0 = 0, cslow_n0 = 0;
    int mosi_hi0 = 0, overlap0 = 0, we_err0 = 0, hi_run0 = 0, last_hi_run0 = 0;

    always @(negedge clk) begin
        sclk_q0 <= sclk0;
        if (cs0) begin
            frise0  <= 0;
            hi_run0 <= hi_run0 + 1;
        end else begin
            if (hi_run0 != 0) last_hi_run0 <= hi_run0;
            hi_run0  <= 0;
            cslow_n0 <= cslow_n0 + 1;
            if (sclk0 && !sclk_q0) begin
                rise0  <= rise0 + 1;
                frise0 <= frise0 + 1;
                if (frise0 < 32) cmd_cap0 <= {cmd_cap0[30:0], mosi0};
                else if (mosi0) mosi_hi0 <= mosi_hi0 + 1;
            end else if (!sclk0 && sclk_q0 && frise0 >= 32) begin
                miso0 <= rom0[(frise0 - 32) / 8][7 - ((frise0 - 32) % 8)];
            end
        end
        if (ena0) begin
            wr0 <= wr0 + 1;
            wq0.push_back({addra0, dina0});
        end
        if (ena0 !== wea0) we_err0 <= we_err0 + 1;
        if (done0) done_n0 <= done_n0 + 1;
        if (busy0) busy_n0 <= busy_n0 + 1;
        if (busy0 && done0) overlap0 <= overlap0 + 1;
    end

    // Monitor and flash model, instance 1
    logic sclk_q1 = 1'b0;
    int   seen1 [0:1023];
    int   tid1 = 0, wr1_snap = 0, idx1 = 0;
    int   rise1 = 0, frise1 = 0, wr1 = 0, done_n1 = 0, aerr1 = 0, derr1 = 0, dup1 = 0, we_err1 = 0;
    int   last_rise1 = -1, min_iv1 = 1000000, max_iv1 = 0;

    always @(negedge clk) begin
        sclk_q1 <= sclk1;
        if (cs1) begin
            frise1     <= 0;
            last_rise1 <= -1;
        end else if (sclk1 && !sclk_q1) begin
            rise1  <= rise1 + 1;
            frise1 <= frise1 + 1;
            if (last_rise1 >= 0) begin
                if (cyc - last_rise1 < min_iv1) min_iv1 <= cyc - last_rise1;
                if (cyc - last_rise1 > max_iv1) max_iv1 <= cyc - last_rise1;
            end
            last_rise1 <= cyc;
        end else if (!sclk1 && sclk_q1 && frise1 >= 32) begin
            miso1 <= rom1[(frise1 - 32) / 8][7 - ((frise1 - 32) % 8)];
        end
        if (ena1) begin
            idx1 = wr1 - wr1_snap;
            if (addra1 !== 10'(base1 + 10'(idx1))) aerr1 <= aerr1 + 1;
            if (idx1 > 1024 || dina1 !== rom1[idx1]) derr1 <= derr1 + 1;
            if (seen1[addra1] == tid1) dup1 <= dup1 + 1;
            seen1[addra1] <= tid1;
            wr1 <= wr1 + 1;
        end
        if (ena1 !== wea1) we_err1 <= we_err1 + 1;
        if (done1) done_n1 <= done_n1 + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] wq_at(input int i);
        if (i < wq0.size()) return 32'(wq0[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic pulse_start(input int sel, input logic [23:0] a, input logic [10:0] n,
                               input logic [9:0] b);
        if (sel == 0) begin
            addr0 = a; cnt0 = n; base0 = b; start0 = 1'b1;
        end else begin
            addr1 = a; cnt1 = n; base1 = b; start1 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int sel, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, d, b, q, mh, cl, gone;
        for (int k = 0; k <= 1024; k++) begin
            rom0[k] = 8'h00;
            rom1[k] = 8'(k * 7 + 3);
        end
        for (int k = 0; k < 1024; k++) seen1[k] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(cs0), 32'd1);
        check("rst_ctrl", 32'({sclk0, mosi0, ena0, wea0, busy0, done0}), 32'd0);
        check("rst_bram", 32'({addra0, dina0}), 32'd0);
        check("rst_div1", 32'({cs1, sclk1, busy1, done1}), 32'b1000);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // T1: 4-byte read from 0x012345 into BRAM 10..13
        rom0[0] = 8'hA5; rom0[1] = 8'h5A; rom0[2] = 8'hFF; rom0[3] = 8'h00;
        r = rise0; w = wr0; d = done_n0; b = busy_n0; q = wq0.size(); mh = mosi_hi0;
        pulse_start(0, 24'h012345, 11'd4, 10'd10);
        check("t1_busy_rise", 32'({busy0, cs0}), 32'b10);
        wait_done("t1", 0, 400);
        repeat (8) @(negedge clk);
        check("t1_cmd", cmd_cap0, 32'h03012345);
        check("t1_rises", 32'(rise0 - r), 32'd64);
        check("t1_writes", 32'(wr0 - w), 32'd4);
        check("t1_w0", wq_at(q), {14'd0, 10'd10, 8'hA5});
        check("t1_w1", wq_at(q + 1), {14'd0, 10'd11, 8'h5A});
        check("t1_w2", wq_at(q + 2), {14'd0, 10'd12, 8'hFF});
        check("t1_w3", wq_at(q + 3), {14'd0, 10'd13, 8'h00});
        check("t1_done", 32'(done_n0 - d), 32'd1);
        check("t1_busy_cycles", 32'(busy_n0 - b), 32'd261);
        check("t1_mosi_in_data", 32'(mosi_hi0 - mh), 32'd0);
        check("t1_idle_bus", 32'({cs0, sclk0, busy0}), 32'b100);
        repeat (10) @(negedge clk);

        // T2: BRAM address wrap past 1023
        rom0[0] = 8'h11; rom0[1] = 8'h22; rom0[2] = 8'h33;
        w = wr0; q = wq0.size();
        pulse_start(0, 24'h000100, 11'd3, 10'd1022);
        wait_done("t2", 0, 400);
        repeat (8) @(negedge clk);
        check("t2_writes", 32'(wr0 - w), 32'd3);
        check("t2_w0", wq_at(q), {14'd0, 10'd1022, 8'h11});
        check("t2_w1", wq_at(q + 1), {14'd0, 10'd1023, 8'h22});
        check("t2_w2", wq_at(q + 2), {14'd0, 10'd0, 8'h33});
        repeat (10) @(negedge clk);

        // T3: zero-length read never touches the bus
        w = wr0; cl = cslow_n0; r = rise0; d = done_n0;
        pulse_start(0, 24'h000000, 11'd0, 10'd5);
        check("t3_busy_first", 32'({busy0, done0}), 32'b10);
        @(negedge clk);
        check("t3_done_next", 32'({busy0, done0}), 32'b01);
        repeat (6) @(negedge clk);
        check("t3_cs_never_low", 32'(cslow_n0 - cl), 32'd0);
        check("t3_no_write_no_edge", 32'({wr0 - w, rise0 - r}), 32'd0);
        check("t3_done", 32'(done_n0 - d), 32'd1);
        repeat (10) @(negedge clk);

        // T4: second start during byte 2 is dropped
        rom0[0] = 8'hC3; rom0[1] = 8'h3C; rom0[2] = 8'h81; rom0[3] = 8'h7E;
        w = wr0; d = done_n0; q = wq0.size();
        pulse_start(0, 24'hABCDEF, 11'd4, 10'd100);
        for (int i = 0; i < 400; i++) begin
            if (wr0 - w >= 2) break;
            @(negedge clk);
        end
        pulse_start(0, 24'h111111, 11'd2, 10'd500);
        wait_done("t4", 0, 400);
        repeat (600) @(negedge clk);
        check("t4_cmd", cmd_cap0, 32'h03ABCDEF);
        check("t4_writes", 32'(wr0 - w), 32'd4);
        check("t4_done", 32'(done_n0 - d), 32'd1);
        check("t4_w3", wq_at(q + 3), {14'd0, 10'd103, 8'h7E});
        check("t4_idle", 32'({busy0, cs0}), 32'b01);

        // T5: reset at SCLK rise 40 aborts; reset beats a simultaneous start
        w = wr0; d = done_n0; q = wq0.size(); r = rise0;
        pulse_start(0, 24'h000040, 11'd4, 10'd200);
        for (int i = 0; i < 400; i++) begin
            if (rise0 - r >= 40) break;
            @(negedge clk);
        end
        reset = 1'b1;
        addr0 = 24'h000080; cnt0 = 11'd4; base0 = 10'd300; start0 = 1'b1;
        @(posedge clk);
        #1;
        check("t5_abort_bus", 32'({cs0, sclk0, busy0, ena0}), 32'b1000);
        @(negedge clk);
        reset = 1'b0;
        gone = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy0) break;
            gone++;
            @(negedge clk);
        end
        start0 = 1'b0;
        check("t5_restart", 32'(busy0), 32'd1);
        wait_done("t5", 0, 400);
        repeat (8) @(negedge clk);
        check("t5_deselect_gap", 32'(last_hi_run0 >= 4), 32'd1);
        check("t5_writes", 32'(wr0 - w), 32'd5);
        check("t5_w_abort", wq_at(q), {14'd0, 10'd200, 8'hC3});
        check("t5_w_new0", wq_at(q + 1), {14'd0, 10'd300, 8'hC3});
        check("t5_w_new3", wq_at(q + 4), {14'd0, 10'd303, 8'h7E});
        check("t5_done", 32'(done_n0 - d), 32'd1);
        check("t5_strobe_pair", 32'(we_err0), 32'd0);
        check("t5_no_overlap", 32'(overlap0), 32'd0);

        // T6: CLK_DIV=1, full 1024-byte read starting at BRAM 7
        tid1 = 1; wr1_snap = wr1; w = wr1; r = rise1; d = done_n1;
        pulse_start(1, 24'h000000, 11'd1024, 10'd7);
        wait_done("t6", 1, 20000);
        repeat (8) @(negedge clk);
        check("t6_writes", 32'(wr1 - w), 32'd1024);
        check("t6_rises", 32'(rise1 - r), 32'd8224);
        check("t6_addr_err", 32'(aerr1), 32'd0);
        check("t6_data_err", 32'(derr1), 32'd0);
        check("t6_dup_addr", 32'(dup1), 32'd0);
        check("t6_sclk_period_min", 32'(min_iv1), 32'd2);
        check("t6_sclk_period_max", 32'(max_iv1), 32'd2);
        check("t6_done", 32'(done_n1 - d), 32'd1);
        repeat (10) @(negedge clk);

        // T7: byte_count above 1024 is clamped
        tid1 = 2; wr1_snap = wr1; w = wr1; r = rise1;
        pulse_start(1, 24'h000200, 11'd1500, 10'd0);
        wait_done("t7", 1, 20000);
        repeat (8) @(negedge clk);
        check("t7_writes", 32'(wr1 - w), 32'd1024);
        check("t7_rises", 32'(rise1 - r), 32'd8224);
        check("t7_errs", 32'(aerr1 + derr1 + dup1 + we_err1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
